// File: rtl/mult3_pkg.sv
// -----------------------------------------------------------------------------
// mult3_pkg
// Shared constants and helpers for the Q8.24 fixed-point datapath blocks.
//   DWIDTH_DEF / FRAC_DEF / NREQ_DEF : default operand width, fraction bits and
//                                      requester count.
//   FX_ONE                           : Q8.24 encoding of 1.0.
//   fx_slice()                       : reduce a full triple product back to the
//                                      operand format.
// -----------------------------------------------------------------------------
package mult3_pkg;

    localparam int DWIDTH_DEF = 32;
    localparam int FRAC_DEF   = 24;
    localparam int NREQ_DEF   = 4;
    localparam int PROD_W     = 3 * DWIDTH_DEF;

    localparam logic [DWIDTH_DEF-1:0] FX_ONE = 32'h0100_0000;

    // A product of three Q.FRAC values carries 3*FRAC fraction bits.
    // Dropping the low 2*FRAC bits brings it back to Q.FRAC. The arithmetic
    // shift truncates toward minus infinity. Keeping only the low DWIDTH bits
    // wraps on overflow. There is no rounding and no saturation.
    function automatic logic [DWIDTH_DEF-1:0] fx_slice(
        input logic signed [PROD_W-1:0] prod,
        input int                       frac
    );
        logic signed [PROD_W-1:0] shifted;
        shifted = prod >>> (2 * frac);
        return shifted[DWIDTH_DEF-1:0];
    endfunction

endpackage

// File: rtl/mult3_rr_sched_if.sv
// -----------------------------------------------------------------------------
// mult3_rr_sched_if
// Request/response bundle between NREQ requesters and the shared multiplier.
//   req_valid[i]      : requester i presents operands
//   req_ready[i]      : one-hot grant back to the requesters
//   req_a/b/c         : operand i in slice [i*DWIDTH +: DWIDTH]
//   rsp_valid[i]      : one-hot tag marking rsp_data as requester i's result
//   rsp_data          : product result
// modport master : requester side
// modport slave  : scheduler side
// -----------------------------------------------------------------------------
interface mult3_rr_sched_if
    import mult3_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int NREQ   = NREQ_DEF
);

    logic [NREQ-1:0]        req_valid;
    logic [NREQ-1:0]        req_ready;
    logic [NREQ*DWIDTH-1:0] req_a;
    logic [NREQ*DWIDTH-1:0] req_b;
    logic [NREQ*DWIDTH-1:0] req_c;
    logic [NREQ-1:0]        rsp_valid;
    logic [DWIDTH-1:0]      rsp_data;

    modport master (
        output req_valid, req_a, req_b, req_c,
        input  req_ready, rsp_valid, rsp_data
    );

    modport slave (
        input  req_valid, req_a, req_b, req_c,
        output req_ready, rsp_valid, rsp_data
    );

endinterface

// File: rtl/mult3_rr_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker.
//   req_i   : request vector
//   ptr_i   : index where the search starts (wraps modulo N)
//   grant_o : one-hot grant of the first set request at or after ptr_i
//   idx_o   : binary index of the granted request
//   any_o   : a grant was issued
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    // Walk the request vector from ptr_i with wrap; the first hit wins.
    always_comb begin : pick
        int j;
        grant_o = '0;
        idx_o   = '0;
        any_o   = 1'b0;
        j       = 0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!any_o && req_i[j]) begin
                any_o      = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IDX_W'(j);
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/mult3_rr_sched.sv
// -----------------------------------------------------------------------------
// mult3_rr_sched
// Time-shares one pipelined 3-input Q8.24 multiplier among NREQ requesters.
// The scheduler takes one operand triple per cycle in round-robin order.
// Each product returns two cycles after its grant, with a one-hot tag.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mult3_rr_sched_if.slave (request handshake, tagged response)
// -----------------------------------------------------------------------------
module mult3_rr_sched
    import mult3_pkg::*;
#(
    parameter int DWIDTH = DWIDTH_DEF,
    parameter int FRAC   = FRAC_DEF,
    parameter int NREQ   = NREQ_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    mult3_rr_sched_if.slave  bus
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int FULL_W = 3 * DWIDTH;

    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [NREQ-1:0]   grant_s;
    logic [IDX_W-1:0]  grant_idx_s;
    logic              any_grant_s;

    logic [DWIDTH-1:0] a_sel_s, b_sel_s, c_sel_s;
    logic [DWIDTH-1:0] a1_q, b1_q, c1_q;
    logic [NREQ-1:0]   tag1_q;
    logic              v1_q;

    logic signed [FULL_W-1:0]     a_ext_s, b_ext_s, c_ext_s, prod_s;
    logic signed [PROD_W-1:0]     prod_wide_s;
    logic        [DWIDTH_DEF-1:0] slice_s;

    logic [NREQ-1:0]   rsp_valid_q;
    logic [DWIDTH-1:0] rsp_data_q;

    rr_pick #(
        .N     (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (bus.req_valid),
        .ptr_i   (rr_ptr_q),
        .grant_o (grant_s),
        .idx_o   (grant_idx_s),
        .any_o   (any_grant_s)
    );

    assign bus.req_ready = grant_s;

    assign a_sel_s = bus.req_a[int'(grant_idx_s) * DWIDTH +: DWIDTH];
    assign b_sel_s = bus.req_b[int'(grant_idx_s) * DWIDTH +: DWIDTH];
    assign c_sel_s = bus.req_c[int'(grant_idx_s) * DWIDTH +: DWIDTH];

    // The pointer moves one past the granted index and wraps at NREQ-1.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (any_grant_s) begin
            if (grant_idx_s == IDX_W'(NREQ - 1)) begin
                rr_ptr_d = '0;
            end else begin
                rr_ptr_d = grant_idx_s + IDX_W'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // Sign-extend before multiplying so the full 3*DWIDTH product is exact.
    assign a_ext_s     = {{(2 * DWIDTH){a1_q[DWIDTH-1]}}, a1_q};
    assign b_ext_s     = {{(2 * DWIDTH){b1_q[DWIDTH-1]}}, b1_q};
    assign c_ext_s     = {{(2 * DWIDTH){c1_q[DWIDTH-1]}}, c1_q};
    assign prod_s      = a_ext_s * b_ext_s * c_ext_s;
    assign prod_wide_s = PROD_W'(prod_s);
    assign slice_s     = fx_slice(prod_wide_s, FRAC);

    // Round-robin pointer register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Stage 1 captures the granted operands and tag. Operands are left stale when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q   <= '0;
            b1_q   <= '0;
            c1_q   <= '0;
            tag1_q <= '0;
            v1_q   <= 1'b0;
        end else begin
            v1_q <= any_grant_s;
            if (any_grant_s) begin
                a1_q   <= a_sel_s;
                b1_q   <= b_sel_s;
                c1_q   <= c_sel_s;
                tag1_q <= grant_s;
            end else begin
                tag1_q <= tag1_q;
            end
        end
    end

    // Stage 2 produces the registered product and its one-hot tag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            rsp_valid_q <= v1_q ? tag1_q : '0;
            if (v1_q) begin
                rsp_data_q <= slice_s[DWIDTH-1:0];
            end else begin
                rsp_data_q <= rsp_data_q;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;

endmodule

// File: doc/mult3_rr_sched.md
Name: mult3_rr_sched

Overview:
- Round-robin scheduler that time-shares one pipelined 3-input Q8.24 multiplier among NREQ requesters, e.g. sigmoid/derivative units in the neuron datapath.
- Accepts one operand triple per cycle through per-requester valid/ready handshakes.
- Returns each fixed-point product two cycles later with a one-hot requester tag.

Parameters:
- DWIDTH, 32, operand and result width (signed two's complement).
- FRAC, 24, fractional bits of the fixed-point format.
- NREQ, 4, number of requesters (2..8).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NREQ  bit i: requester i presents operands.
- req_ready  out  NREQ  one-hot grant; bit i high means requester i's operands are taken this cycle.
- req_a  in  NREQ*DWIDTH  first operand; requester i occupies slice [i*DWIDTH +: DWIDTH]. Same layout for req_b and req_c.
- req_b  in  NREQ*DWIDTH  second operand.
- req_c  in  NREQ*DWIDTH  third operand.
- rsp_valid  out  NREQ  one-hot, registered; bit i marks rsp_data as belonging to requester i.
- rsp_data  out  DWIDTH  product result, registered.

Behaviour:
- **Reset:**
  - rst_n low asynchronously clears rsp_valid, rsp_data, all pipeline valid bits, tags and data, and rr_ptr (to 0).
  - req_ready is combinational and reads 0 while no request is valid.
- **Arbitration (combinational):**
  - Search req_valid starting at index rr_ptr, wrapping modulo NREQ. The first set bit g is granted and req_ready = 1<<g.
  - No valid request: req_ready = 0.
  - req_ready never depends on req_a/b/c.
- **Handshake:** transfer occurs when req_valid[i] & req_ready[i]. A requester holds valid and operands stable until granted; valid may not be withdrawn once asserted.
- **Pointer:** on a grant, rr_ptr <= (g+1) mod NREQ next edge; otherwise unchanged. This gives fair rotation and no starvation. The maximum wait is NREQ-1 cycles.
- **Stage 1 (edge after grant):**
  - Register A, B, C of requester g, the tag 1<<g, and v1=1.
  - With no grant, v1=0; data registers may hold stale values.
- **Stage 2 (next edge):**
  - Full signed product P = A*B*C, at least 3*DWIDTH bits.
  - rsp_data <= P[DWIDTH+2*FRAC-1 : 2*FRAC], i.e. truncation toward minus infinity with wrap on overflow. No rounding, no saturation.
  - rsp_valid <= v1 ? tag1 : 0.
- **Latency and throughput:**
  - Grant in cycle n produces a response in cycle n+2 (visible after the second edge).
  - Throughput is one result per cycle. No response backpressure; requesters must accept rsp_valid unconditionally.
- **Simultaneous events:**
  - A requester may receive a response and a new grant in the same cycle.
  - Consecutive grants to the same requester are allowed when it is the only valid one.
  - Responses stay in grant order.
- **Reset mid-operation:** in-flight results are discarded. No rsp_valid is issued after rst_n rises for operations accepted before reset.
- rsp_valid is at most one-hot, never multi-hot.

Decomposition:
- **Shared package (mult3_pkg):**
  - Constants DWIDTH_DEF=32, FRAC_DEF=24, NREQ_DEF=4.
  - FX_ONE = 1<<FRAC (Q8.24 value 1.0).
  - Function fx_slice(product) implementing the truncation rule; shared with other fixed-point blocks.
- **One combinational sub-module:** rr_pick (inputs: req vector, start pointer; outputs: one-hot grant, grant index, any_grant). Reused by other shared-resource schedulers.
- Pipeline and pointer registers stay in mult3_rr_sched.

Test Plan:
1. **Single request:** requester 0 sends A=0x02000000 (2.0), B=0x00800000 (0.5), C=0x03000000 (3.0).
   - req_ready=0001 that cycle.
   - Two cycles later rsp_valid=0001, rsp_data=0x03000000.
2. **Signed operands:** requester 2 sends A=0xFF000000 (-1.0), B=C=0x02000000.
   - rsp_valid=0100, rsp_data=0xFC000000 (-4.0).
   - Also A=0xFFFFFFFF, B=C=FX_ONE gives 0xFFFFFFFF.
3. **Round robin:** all four req_valid held high for 8 cycles from reset.
   - Grants 0,1,2,3,0,1,2,3.
   - Responses in the same order, one per cycle, starting cycle 2.
4. **Fairness/skip:** only requesters 1 and 3 valid with rr_ptr=0.
   - Grants 1,3,1,3.
   - Requester 3 never waits more than 1 cycle.
5. **Back-to-back single requester:** requester 0 valid for 3 cycles with products 1.0, 2.0, 4.0.
   - Three consecutive responses 0x01000000, 0x02000000, 0x04000000.
6. **Reset mid-operation:** pulse rst_n low for half a cycle with two operations in flight.
   - rsp_valid drops to 0 immediately and stays 0 after release until a new grant.
   - rr_ptr returns to 0, so the next grant with all valid goes to requester 0.
